// File: rtl/dqn_fixed_pkg.sv
// ============================================================================
//  Package     : dqn_fixed_pkg
//  Description : Shared Q6.10 fixed-point constants, typedefs and the MAC
//                sequencer state encoding used by neuron_mac and later layers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dqn_fixed_pkg;

    // Q6.10 format
    localparam int Q_DATA_W   = 16;
    localparam int Q_FRAC     = 10;
    localparam logic [15:0] Q_ONE = 16'h0400;
    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;
    localparam int ROUND_HALF = 512;

    // Accumulator: 32-bit Q12.20 product plus 8 guard bits (up to 256 terms)
    localparam int MAC_ACC_W  = 40;

    typedef logic signed [Q_DATA_W-1:0]  q6_10_t;
    typedef logic signed [MAC_ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2,
        S_HOLD  = 2'd3
    } mac_state_t;

endpackage

`default_nettype wire

// File: rtl/fxp_round_sat.sv
// ============================================================================
//  Module      : fxp_round_sat
//  Description : Combinational round-half-up, arithmetic right shift by FRAC
//                and narrowing of a wide accumulator to a DATA_W result.
//                With MAC_SAT_EN defined the result is clamped to the signed
//                DATA_W range and sat_o flags the clamp; otherwise the result
//                wraps (two's complement) and sat_o is tied low.
//  Ports       : acc_i  in  ACC_W   signed accumulator (FRAC*2 binary point
//                                   already aligned by the caller)
//                z_o    out DATA_W  rounded / narrowed result
//                sat_o  out 1       result was clamped
//  Macro       : MAC_SAT_EN
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fxp_round_sat
    import dqn_fixed_pkg::*;
#(
    parameter int ACC_W  = MAC_ACC_W,
    parameter int DATA_W = Q_DATA_W,
    parameter int FRAC   = Q_FRAC
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] z_o,
    output logic                     sat_o
);

    localparam int RW = ACC_W - FRAC;
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);

    logic [ACC_W-1:0] sum;
    logic [RW-1:0]    r;
    logic             unused_frac;

    assign sum = acc_i + HALF;
    // Dropping the low FRAC bits is the arithmetic shift; sign is preserved
    // because the kept field still carries the accumulator MSB.
    assign r           = sum[ACC_W-1:FRAC];
    assign unused_frac = ^sum[FRAC-1:0];

`ifdef MAC_SAT_EN
    logic [RW-DATA_W:0] hi;
    logic               fits;

    // Value fits when every bit above the result sign bit equals that sign.
    assign hi   = r[RW-1:DATA_W-1];
    assign fits = (&hi) | ~(|hi);

    always_comb begin
        z_o   = r[DATA_W-1:0];
        sat_o = 1'b0;
        if (!fits) begin
            sat_o = 1'b1;
            z_o   = r[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^r[RW-1:DATA_W];
    assign z_o       = r[DATA_W-1:0];
    assign sat_o     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/neuron_mac.sv
// ============================================================================
//  Module      : neuron_mac
//  Description : Streams N_INPUTS x/w pairs, accumulates sum(x*w) + bias in
//                Q12.20, then rounds and narrows to Q6.10 for the sigmoid
//                stage. act_ctrl = 4'b1111 while the result is presented.
//  Ports       : clk, rst_n        clock, async active-low reset
//                start, bias       begin neuron / bias (latched in IDLE)
//                in_valid/in_ready x/w pair handshake; x, w operands
//                out_valid/out_ready result handshake; z result, sat clamp
//                act_ctrl          activation stage control
//                busy              sequencer not idle
//  Macro       : MAC_SAT_EN  (clamp + sat flag; undefined = wrap, sat = 0)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module neuron_mac
    import dqn_fixed_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = Q_DATA_W,
    parameter int FRAC     = Q_FRAC,
    parameter int ACC_W    = MAC_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] z,
    output logic [3:0]        act_ctrl,
    output logic              sat,
    output logic              busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam int PROD_W = 2 * DATA_W;

    mac_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] bias_q,  bias_d;
    logic [DATA_W-1:0] z_q,     z_d;
    logic              sat_q,   sat_d;

    logic              beat;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  total;
    logic [DATA_W-1:0] rs_z;
    logic              rs_sat;

    // Multiplying the sign-extended operands and keeping the low 2*DATA_W
    // bits gives the exact signed product.
    assign prod     = {{DATA_W{x[DATA_W-1]}}, x} * {{DATA_W{w[DATA_W-1]}}, w};
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Bias moved onto the product binary point (FRAC -> 2*FRAC).
    assign total = acc_q + {{(ACC_W-DATA_W-FRAC){bias_q[DATA_W-1]}},
                            bias_q, {FRAC{1'b0}}};

    fxp_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_round_sat (
        .acc_i (total),
        .z_o   (rs_z),
        .sat_o (rs_sat)
    );

    assign in_ready  = (state_q == S_ACCUM);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == S_HOLD);
    assign act_ctrl  = out_valid ? 4'b1111 : 4'b0000;
    assign busy      = (state_q != S_IDLE);
    assign z         = z_q;
    assign sat       = sat_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        z_d     = z_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                z_d     = rs_z;
                sat_d   = rs_sat;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bias_q  <= '0;
            z_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            z_q     <= z_d;
            sat_q   <= sat_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
Upstream feeder for the sigmoid activation stage. Computes one neuron pre-activation z = sum(x_i*w_i) + b over N_INPUTS streamed input/weight pairs in Q6.10 fixed-point. Rounds and saturates the result to 16-bit Q6.10 and presents it on z with act_ctrl = 4'b1111, so the activation stage evaluates it directly.

Parameters:
N_INPUTS, 4, input/weight pairs per neuron; legal range 1..256.
DATA_W, 16, width of x, w, bias and z (signed Q6.10).
FRAC, 10, fractional bits of every operand and of z.
ACC_W, 40, accumulator width; 32-bit product + 8 guard bits covers N_INPUTS <= 256.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a neuron; sampled only in IDLE.
bias  in  16  signed Q6.10 bias; latched on accepted start.
in_valid  in  1  x/w pair valid.
in_ready  out  1  block accepts pair.
x  in  16  signed Q6.10 input.
w  in  16  signed Q6.10 weight.
out_valid  out  1  z valid.
out_ready  in  1  consumer accepts z.
z  out  16  signed Q6.10 pre-activation, to activation stage z.
act_ctrl  out  4  to activation stage ctrl; 4'b1111 while out_valid, else 4'b0000.
sat  out  1  z was clamped; valid with out_valid.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE. acc = 0, cnt = 0, z = 0, out_valid = 0, in_ready = 0, act_ctrl = 0, sat = 0, busy = 0.
- FSM states: IDLE, ACCUM, FINAL, HOLD.
- IDLE: start=1 latches bias, clears acc and cnt, moves to ACCUM. in_ready = 1 from the next cycle.
- ACCUM: a beat is in_valid && in_ready. On each beat acc += sext(x*w) (signed 32-bit product, Q12.20) and cnt++. The beat with cnt == N_INPUTS-1 moves to FINAL with in_ready = 0. No beat: hold. in_ready is a registered state decode.
- FINAL (1 cycle):
  - t = acc + (sext(bias) << FRAC).
  - r = (t + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift).
  - Clamp r to [-32768, 32767]; sat = 1 if clamped.
  - Register z and sat, set out_valid = 1 and act_ctrl = 4'b1111, go to HOLD.
- Latency: out_valid rises on the 2nd rising edge after the last beat.
- HOLD: z, sat, out_valid and act_ctrl are held stable until out_ready = 1. Then out_valid = 0, act_ctrl = 0 and state goes to IDLE on that edge. z keeps its value; the activation stage holds when ctrl != 1111.
- start outside IDLE is ignored, including the HOLD handshake cycle; bias is not re-latched.
- x/w presented while in_ready = 0 are ignored.
- N_INPUTS = 1: one beat, then FINAL.
- rst_n asserted mid-operation aborts; the next start has no residue from the aborted neuron.

Optional Feature:
MAC_SAT_EN.
- Defined: clamp as above; sat is driven.
- Undefined: z = r[15:0] (two's-complement wrap); sat tied 0; the clamp logic is not built.

Decomposition:
- Package dqn_fixed_pkg:
  - Q6.10 constants: Q_DATA_W = 16, Q_FRAC = 10, Q_ONE = 16'h0400, Q_MAX = 16'h7FFF, Q_MIN = 16'h8000, ROUND_HALF = 512.
  - Typedefs q6_10_t (signed 16) and acc_t (signed ACC_W).
  - FSM state enum mac_state_t.
- Sub-module fxp_round_sat: combinational round/shift/clamp from acc_t to q6_10_t with a sat flag, reusable by later layers. The multiply stays inline.

Test Plan:
- Basic (N=4, bias 0): x = 0x0400 and w = 0x0200 on all four beats -> z = 0x0800, sat = 0, act_ctrl = 4'hF, out_valid 2 edges after the last beat.
- Rounding: beat 0 x = 0x0001, w = 0x0200; beats 1-3 zero; bias 0 -> z = 0x0001. Same beats with bias 0xFC00 -> z = 0xFC01.
- Saturation: x = w = 0x7C00 (31.0) on all beats, bias 0 -> z = 0x7FFF, sat = 1. Without MAC_SAT_EN -> z = 0x1000, sat = 0. All w = 0x8400 -> z = 0x8000, sat = 1.
- Backpressure: random in_valid gaps, out_ready low for 5 cycles -> z, act_ctrl and out_valid stay stable. A start pulse during HOLD is ignored; busy drops only after the out_ready edge.
- Reset mid-ACCUM: assert rst_n low after 2 beats -> all outputs 0 immediately. A fresh start with case-1 data then gives z = 0x0800.
- Start during ACCUM: pulse start with bias 0x0400 after beat 1 (original bias 0) -> ignored, case-1 result 0x0800 unchanged.
